// File: rtl/ofdm_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ofdm_rx_pkg
// Purpose  : Shared OFDM receiver types and default timing parameters.
// Revision : 1.0 - initial release
// ============================================================================
package ofdm_rx_pkg;

    localparam int c_LTS_PEAK_GAP = 64;
    localparam int c_LTS_GAP_TOL  = 1;
    localparam int c_GI_LEN       = 16;
    localparam int c_SYM_LEN      = 80;

    typedef enum logic [2:0] {
        LTS_IDLE      = 3'd0,
        LTS_SEARCH_P1 = 3'd1,
        LTS_TRACK_P1  = 3'd2,
        LTS_WAIT_P2   = 3'd3,
        LTS_ALIGNED   = 3'd4
    } lts_state_t;

    // Bits needed to hold values 0..max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lts_peak_align.sv
`default_nettype none
// ============================================================================
// Module   : lts_peak_align
// Purpose  : Confirms the LTS correlation peak pair and emits data-symbol
//            start pulses aligned to the second peak.
// Revision : 1.0 - initial release
// ============================================================================
module lts_peak_align
    import ofdm_rx_pkg::*;
#(
    parameter int PEAK_GAP = c_LTS_PEAK_GAP,
    parameter int GAP_TOL  = c_LTS_GAP_TOL,
    parameter int GI_LEN   = c_GI_LEN,
    parameter int SYM_LEN  = c_SYM_LEN
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [31:0] lts_cross_corr,
    input  logic        lts_cross_corr_valid,
    input  logic [31:0] corr_threshold,
    output logic        lts_detected,
    output logic [31:0] lts_peak_value,
    output logic        symbol_start,
    output logic        lts_fail
);

    localparam int c_D_MAX  = PEAK_GAP + GAP_TOL;
    localparam int c_D_W    = cnt_width(c_D_MAX);
    localparam int c_D2_MAX = GI_LEN + 1;
    localparam int c_D2_W   = cnt_width(c_D2_MAX);
    localparam int c_SYM_W  = cnt_width(SYM_LEN - 1);

    localparam logic [c_D_W-1:0]   c_D_TRACK_END = c_D_W'(2);
    localparam logic [c_D_W-1:0]   c_D_LO        = c_D_W'(PEAK_GAP - GAP_TOL);
    localparam logic [c_D_W-1:0]   c_D_HI        = c_D_W'(c_D_MAX);
    localparam logic [c_D2_W-1:0]  c_D2_FIRST    = c_D2_W'(c_D2_MAX);
    localparam logic [c_SYM_W-1:0] c_SYM_LAST    = c_SYM_W'(SYM_LEN - 1);

    lts_state_t         r_state;
    logic [c_D_W-1:0]   r_d;
    logic [c_D2_W-1:0]  r_d2;
    logic [c_SYM_W-1:0] r_sym;
    logic [31:0]        r_peak1;
    logic [31:0]        r_cand;
    logic               r_cand_vld;
    logic               r_detected;
    logic [31:0]        r_peak_value;
    logic               r_sym_start;
    logic               r_fail;

    logic               w_above;
    logic [c_D_W-1:0]   w_d_inc;
    logic [c_D2_W-1:0]  w_d2_inc;
    logic               w_in_window;
    logic               w_take;

    assign w_above     = lts_cross_corr > corr_threshold;
    assign w_d_inc     = (r_d == c_D_HI) ? r_d : r_d + c_D_W'(1);
    assign w_d2_inc    = (r_d2 == c_D2_FIRST) ? r_d2 : r_d2 + c_D2_W'(1);
    assign w_in_window = (w_d_inc >= c_D_LO) && (w_d_inc <= c_D_HI);
    // Strict compare against the held candidate keeps the earliest on ties.
    assign w_take      = w_in_window && w_above && (!r_cand_vld || (lts_cross_corr > r_cand));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= LTS_IDLE;
            r_d          <= '0;
            r_d2         <= '0;
            r_sym        <= '0;
            r_peak1      <= '0;
            r_cand       <= '0;
            r_cand_vld   <= 1'b0;
            r_detected   <= 1'b0;
            r_peak_value <= '0;
            r_sym_start  <= 1'b0;
            r_fail       <= 1'b0;
        end else begin
            r_detected  <= 1'b0;
            r_sym_start <= 1'b0;
            r_fail      <= 1'b0;
            if (!enable) begin
                r_state    <= LTS_IDLE;
                r_d        <= '0;
                r_d2       <= '0;
                r_sym      <= '0;
                r_peak1    <= '0;
                r_cand     <= '0;
                r_cand_vld <= 1'b0;
            end else begin
                case (r_state)
                    LTS_IDLE: begin
                        r_state <= LTS_SEARCH_P1;
                    end
                    LTS_SEARCH_P1: begin
                        if (lts_cross_corr_valid && w_above) begin
                            r_peak1 <= lts_cross_corr;
                            r_d     <= '0;
                            r_state <= LTS_TRACK_P1;
                        end
                    end
                    LTS_TRACK_P1: begin
                        if (lts_cross_corr_valid) begin
                            if (lts_cross_corr > r_peak1) begin
                                r_peak1 <= lts_cross_corr;
                                r_d     <= '0;
                            end else begin
                                r_d <= w_d_inc;
                                if (w_d_inc == c_D_TRACK_END) begin
                                    r_state    <= LTS_WAIT_P2;
                                    r_cand_vld <= 1'b0;
                                    r_d2       <= '0;
                                end
                            end
                        end
                    end
                    LTS_WAIT_P2: begin
                        if (lts_cross_corr_valid) begin
                            r_d <= w_d_inc;
                            // r_d2 measures distance from the current candidate.
                            if (w_take) begin
                                r_cand     <= lts_cross_corr;
                                r_cand_vld <= 1'b1;
                                r_d2       <= '0;
                            end else if (r_cand_vld) begin
                                r_d2 <= w_d2_inc;
                            end
                            if (w_d_inc == c_D_HI) begin
                                if (w_take || r_cand_vld) begin
                                    r_state      <= LTS_ALIGNED;
                                    r_detected   <= 1'b1;
                                    r_peak_value <= w_take ? lts_cross_corr : r_cand;
                                    r_sym        <= '0;
                                end else begin
                                    r_state <= LTS_SEARCH_P1;
                                    r_fail  <= 1'b1;
                                    r_d     <= '0;
                                    r_d2    <= '0;
                                end
                            end
                        end
                    end
                    LTS_ALIGNED: begin
                        if (lts_cross_corr_valid) begin
                            if (r_d2 != c_D2_FIRST) begin
                                r_d2 <= w_d2_inc;
                                if (w_d2_inc == c_D2_FIRST) begin
                                    r_sym_start <= 1'b1;
                                    r_sym       <= '0;
                                end
                            end else if (r_sym == c_SYM_LAST) begin
                                r_sym       <= '0;
                                r_sym_start <= 1'b1;
                            end else begin
                                r_sym <= r_sym + c_SYM_W'(1);
                            end
                        end
                    end
                    default: begin
                        r_state <= LTS_IDLE;
                    end
                endcase
            end
        end
    end

    assign lts_detected   = r_detected;
    assign lts_peak_value = r_peak_value;
    assign symbol_start   = r_sym_start;
    assign lts_fail       = r_fail;

endmodule
`default_nettype wire

// File: tb/tb_lts_peak_align.sv
`default_nettype none
// ============================================================================
// Module   : tb_lts_peak_align
// Purpose  : Self-checking bench for lts_peak_align (directed table + random).
// Revision : 1.0 - initial release
// ============================================================================
module tb_lts_peak_align;

    localparam int PEAK_GAP = 64;
    localparam int GAP_TOL  = 1;
    localparam int GI_LEN   = 16;
    localparam int SYM_LEN  = 80;
    localparam int MAXN     = 400;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        valid = 1'b0;
    logic [31:0] corr = '0;
    logic [31:0] thr = '0;
    logic        lts_detected;
    logic [31:0] lts_peak_value;
    logic        symbol_start;
    logic        lts_fail;

    lts_peak_align #(
        .PEAK_GAP (PEAK_GAP),
        .GAP_TOL  (GAP_TOL),
        .GI_LEN   (GI_LEN),
        .SYM_LEN  (SYM_LEN)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .enable               (enable),
        .lts_cross_corr       (corr),
        .lts_cross_corr_valid (valid),
        .corr_threshold       (thr),
        .lts_detected         (lts_detected),
        .lts_peak_value       (lts_peak_value),
        .symbol_start         (symbol_start),
        .lts_fail             (lts_fail)
    );

    always #5 clk = ~clk;

    typedef struct {
        int p1a_i; int p1a_v; int p1b_i; int p1b_v;
        int p2a_i; int p2a_v; int p2b_i; int p2b_v;
        int gap_at;
        int exp_det_cnt; int exp_det_idx; int exp_val;
        int exp_sym0; int exp_sym1;
        int exp_fail_cnt; int exp_fail_idx;
    } vec_t;

    vec_t tbl [10];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   samp [MAXN];
    int   vcount = 0;
    int   vbase = 0;
    int   q_det[$], q_val[$], q_fail[$], q_sym[$];
    int   m_det[$], m_val[$], m_fail[$], m_sym[$];

    // Index of valid samples accepted while enabled; events are tagged with it.
    always @(posedge clk) if (!rst && enable && valid) vcount++;

    always @(negedge clk) begin
        if (lts_detected) begin
            q_det.push_back(vcount - vbase - 1);
            q_val.push_back(int'(lts_peak_value));
        end
        if (lts_fail)     q_fail.push_back(vcount - vbase - 1);
        if (symbol_start) q_sym.push_back(vcount - vbase - 1);
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_q();
        q_det.delete(); q_val.delete(); q_fail.delete(); q_sym.delete();
        vbase = vcount;
    endtask

    task automatic idle(input int k);
        repeat (k) begin @(negedge clk); valid = 1'b0; end
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1; valid = 1'b0;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic stream(input int from, input int to, input int gap_at, input int gap_max);
        int ng;
        for (int i = from; i < to; i++) begin
            @(negedge clk); valid = 1'b1; corr = 32'(samp[i]);
            ng = (i == gap_at) ? 10 : ((gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0);
            idle(ng);
        end
        idle(1);
    endtask

    // Reference: scan the valid-sample stream with the peak-pair rules directly.
    task automatic model_run(input int n, input int t);
        int i, j, p, k, best;
        m_det.delete(); m_val.delete(); m_fail.delete(); m_sym.delete();
        i = 0;
        while (i < n) begin
            j = i;
            while (j < n && samp[j] <= t) j++;
            if (j >= n) break;
            p = j; k = j + 1;
            while (k < n && k - p <= 2) begin
                if (samp[k] > samp[p]) p = k;
                k++;
            end
            if (k - p <= 2) break;
            if (p + PEAK_GAP + GAP_TOL >= n) break;
            best = -1;
            for (int w = p + PEAK_GAP - GAP_TOL; w <= p + PEAK_GAP + GAP_TOL; w++)
                if (samp[w] > t && (best < 0 || samp[w] > samp[best])) best = w;
            if (best >= 0) begin
                m_det.push_back(p + PEAK_GAP + GAP_TOL);
                m_val.push_back(samp[best]);
                for (int s = best + GI_LEN + 1; s < n; s += SYM_LEN) m_sym.push_back(s);
                break;
            end
            m_fail.push_back(p + PEAK_GAP + GAP_TOL);
            i = p + PEAK_GAP + GAP_TOL + 1;
        end
    endtask

    task automatic cmp_model(input string tag);
        chk({tag, " det_cnt"}, q_det.size(), m_det.size());
        chk({tag, " fail_cnt"}, q_fail.size(), m_fail.size());
        chk({tag, " sym_cnt"}, q_sym.size(), m_sym.size());
        for (int i = 0; i < q_det.size() && i < m_det.size(); i++) begin
            chk({tag, " det_idx"}, q_det[i], m_det[i]);
            chk({tag, " peak_val"}, q_val[i], m_val[i]);
        end
        for (int i = 0; i < q_fail.size() && i < m_fail.size(); i++)
            chk({tag, " fail_idx"}, q_fail[i], m_fail[i]);
        for (int i = 0; i < q_sym.size() && i < m_sym.size(); i++)
            chk({tag, " sym_idx"}, q_sym[i], m_sym[i]);
    endtask

    initial begin
        tbl[0] = '{10, 900, -1,   0, 74, 950, -1,   0, -1, 1, 75, 950, 91, 171, 0, -1};
        tbl[1] = '{10, 600, 11, 800, 75, 700, -1,   0, -1, 1, 76, 700, 92, 172, 0, -1};
        tbl[2] = '{10, 900, -1,   0, -1,   0, -1,   0, -1, 0, -1,   0, -1,  -1, 1, 75};
        tbl[3] = '{10, 900, -1,   0, 74, 950, -1,   0, 40, 1, 75, 950, 91, 171, 0, -1};
        tbl[4] = '{10, 900, -1,   0, 73, 700, 75, 700, -1, 1, 75, 700, 90, 170, 0, -1};
        tbl[5] = '{10, 900, 12, 900, 74, 800, -1,   0, -1, 1, 75, 800, 91, 171, 0, -1};
        tbl[6] = '{10, 900, -1,   0, 76, 990, -1,   0, -1, 0, -1,   0, -1,  -1, 2, 75};
        tbl[7] = '{10, 900, -1,   0, 74, 500, -1,   0, -1, 0, -1,   0, -1,  -1, 1, 75};
        tbl[8] = '{10, 900, -1,   0, 75, 950, -1,   0, -1, 1, 75, 950, 92, 172, 0, -1};
        tbl[9] = '{10, 900, -1,   0, 72, 990, -1,   0, -1, 0, -1,   0, -1,  -1, 1, 75};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst lts_detected", int'(lts_detected), 0);
        chk("rst symbol_start", int'(symbol_start), 0);
        chk("rst lts_fail", int'(lts_fail), 0);
        chk("rst lts_peak_value", int'(lts_peak_value), 0);
        rst = 1'b0;

        // Directed table
        thr = 32'd500;
        for (int c = 0; c < 10; c++) begin
            for (int i = 0; i < 250; i++) samp[i] = 50;
            if (tbl[c].p1a_i >= 0) samp[tbl[c].p1a_i] = tbl[c].p1a_v;
            if (tbl[c].p1b_i >= 0) samp[tbl[c].p1b_i] = tbl[c].p1b_v;
            if (tbl[c].p2a_i >= 0) samp[tbl[c].p2a_i] = tbl[c].p2a_v;
            if (tbl[c].p2b_i >= 0) samp[tbl[c].p2b_i] = tbl[c].p2b_v;
            do_reset(); clear_q(); enable = 1'b1; idle(2);
            stream(0, 250, tbl[c].gap_at, 0); idle(4);
            chk($sformatf("t%0d det_cnt", c), q_det.size(), tbl[c].exp_det_cnt);
            chk($sformatf("t%0d det_idx", c), (q_det.size() > 0) ? q_det[0] : -1, tbl[c].exp_det_idx);
            chk($sformatf("t%0d peak_val", c), (q_val.size() > 0) ? q_val[0] : 0, tbl[c].exp_val);
            chk($sformatf("t%0d sym0", c), (q_sym.size() > 0) ? q_sym[0] : -1, tbl[c].exp_sym0);
            chk($sformatf("t%0d sym1", c), (q_sym.size() > 1) ? q_sym[1] : -1, tbl[c].exp_sym1);
            chk($sformatf("t%0d fail_cnt", c), q_fail.size(), tbl[c].exp_fail_cnt);
            chk($sformatf("t%0d fail_idx", c), (q_fail.size() > 0) ? q_fail[0] : -1, tbl[c].exp_fail_idx);
        end

        // Enable dropped during WAIT_P2, then a fresh pair
        for (int i = 0; i < 250; i++) samp[i] = 50;
        samp[10] = 900;
        do_reset(); clear_q(); enable = 1'b1; idle(2);
        stream(0, 40, -1, 0);
        @(negedge clk); enable = 1'b0; idle(2);
        @(negedge clk); enable = 1'b1; idle(2);
        chk("en_drop early_det", q_det.size(), 0);
        chk("en_drop early_fail", q_fail.size(), 0);
        for (int i = 0; i < 250; i++) samp[i] = 50;
        samp[34] = 950; samp[98] = 960;
        clear_q();
        stream(0, 200, -1, 0); idle(4);
        chk("en_drop det_cnt", q_det.size(), 1);
        chk("en_drop det_idx", (q_det.size() > 0) ? q_det[0] : -1, 99);
        chk("en_drop peak_val", (q_val.size() > 0) ? q_val[0] : 0, 960);
        chk("en_drop sym0", (q_sym.size() > 0) ? q_sym[0] : -1, 115);
        chk("en_drop fail_cnt", q_fail.size(), 0);

        // Enable low retains peak value and silences everything
        @(negedge clk); enable = 1'b0; idle(2); clear_q();
        for (int i = 0; i < 200; i++) samp[i] = (i % 64 == 5) ? 990 : 50;
        stream(0, 200, -1, 0); idle(2);
        chk("en_low peak_val", int'(lts_peak_value), 960);
        chk("en_low events", q_det.size() + q_fail.size() + q_sym.size(), 0);

        // Reset pulse during ALIGNED
        for (int i = 0; i < 250; i++) samp[i] = 50;
        samp[10] = 900; samp[74] = 950;
        do_reset(); clear_q(); enable = 1'b1; idle(2);
        stream(0, 100, -1, 0);
        chk("rst_al det_cnt", q_det.size(), 1);
        chk("rst_al sym0", (q_sym.size() > 0) ? q_sym[0] : -1, 91);
        chk("rst_al peak_before", int'(lts_peak_value), 950);
        @(negedge clk); rst = 1'b1; valid = 1'b1; corr = 32'd50;
        @(negedge clk); rst = 1'b0; valid = 1'b0;
        chk("rst_al peak_val", int'(lts_peak_value), 0);
        chk("rst_al detected", int'(lts_detected), 0);
        chk("rst_al sym_start", int'(symbol_start), 0);
        chk("rst_al fail", int'(lts_fail), 0);
        clear_q();
        stream(100, 250, -1, 0); idle(4);
        chk("rst_al post_events", q_det.size() + q_fail.size() + q_sym.size(), 0);

        // Randomized runs against the reference model
        for (int r = 0; r < 20; r++) begin
            int t, n, p;
            t = 400 + int'($urandom_range(200, 0));
            n = 300;
            for (int i = 0; i < n; i++)
                samp[i] = ($urandom_range(99, 0) < 4) ? int'($urandom_range(1500, 0))
                                                      : int'($urandom_range(t, 0));
            if (r % 4 != 3) begin
                p = int'($urandom_range(120, 5));
                samp[p] = t + 1 + int'($urandom_range(600, 0));
                samp[p + 63 + int'($urandom_range(2, 0))] = t + 1 + int'($urandom_range(600, 0));
            end
            thr = 32'(t);
            model_run(n, t);
            do_reset(); clear_q(); enable = 1'b1; idle(2);
            stream(0, n, -1, 3); idle(4);
            cmp_model($sformatf("rnd%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
